// File: rtl/clock_reset_sequencer_if.sv
// Bus between the 6809 clock/reset sequencer and its consumers: memory ready and
// soft reset in, Q/E clocks, CPU reset, cycle strobe and stretch status out.
interface clock_reset_sequencer_if;
    logic soft_rst;
    logic mrdy;
    logic qclk;
    logic eclk;
    logic cpu_reset_n;
    logic ecycle_stb;
    logic stretch_active;

    modport master (
        input  soft_rst,
        input  mrdy,
        output qclk,
        output eclk,
        output cpu_reset_n,
        output ecycle_stb,
        output stretch_active
    );

    modport slave (
        output soft_rst,
        output mrdy,
        input  qclk,
        input  eclk,
        input  cpu_reset_n,
        input  ecycle_stb,
        input  stretch_active
    );
endinterface

// File: rtl/clock_reset_sequencer.sv
// 6809 Q/E clock generator (four master clocks per E) with CPU reset hold counter.
// Define CLKSEQ_STRETCH_EN to compile in mrdy-driven E-high stretching.
module clock_reset_sequencer #(
    parameter int RESET_ECYCLES = 16,
    parameter int STRETCH_MAX   = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    clock_reset_sequencer_if.master   bus
);

`ifdef CLKSEQ_STRETCH_EN
    typedef enum logic [2:0] {PH0, PH1, PH2, PH3, STRETCH} state_t;
    localparam logic [7:0] STRETCH_LAST = 8'(STRETCH_MAX - 1);
    logic [7:0] scnt_q, scnt_nx;
`else
    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} state_t;
    logic unused_mrdy;
    assign unused_mrdy = bus.mrdy;
`endif

    localparam logic [7:0] HOLD_LAST = 8'(RESET_ECYCLES);

    state_t     state, state_nx;
    logic       qclk_q, qclk_nx;
    logic       eclk_q, eclk_nx;
    logic       stb_q, stb_nx;
    logic       rstn_q, rstn_nx;
    logic [7:0] hold_q, hold_nx;
    logic [7:0] hold_inc;

    assign hold_inc = hold_q + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= PH0;
            qclk_q <= 1'b0;
            eclk_q <= 1'b0;
            stb_q  <= 1'b0;
            rstn_q <= 1'b0;
            hold_q <= '0;
`ifdef CLKSEQ_STRETCH_EN
            scnt_q <= '0;
`endif
        end else begin
            state  <= state_nx;
            qclk_q <= qclk_nx;
            eclk_q <= eclk_nx;
            stb_q  <= stb_nx;
            rstn_q <= rstn_nx;
            hold_q <= hold_nx;
`ifdef CLKSEQ_STRETCH_EN
            scnt_q <= scnt_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        qclk_nx  = qclk_q;
        eclk_nx  = eclk_q;
        stb_nx   = 1'b0;
        rstn_nx  = rstn_q;
        hold_nx  = hold_q;
`ifdef CLKSEQ_STRETCH_EN
        scnt_nx  = scnt_q;
`endif
        case (state)
            PH0: begin
                qclk_nx  = 1'b1;
                state_nx = PH1;
            end
            PH1: begin
                eclk_nx  = 1'b1;
                state_nx = PH2;
            end
            PH2: begin
                qclk_nx  = 1'b0;
`ifdef CLKSEQ_STRETCH_EN
                state_nx = bus.mrdy ? PH3 : STRETCH;
`else
                state_nx = PH3;
`endif
            end
`ifdef CLKSEQ_STRETCH_EN
            STRETCH: begin
                qclk_nx = 1'b0;
                eclk_nx = 1'b1;
                // Forced release keeps a stuck mrdy from freezing the CPU forever
                if (bus.mrdy || scnt_q == STRETCH_LAST) begin
                    state_nx = PH3;
                    scnt_nx  = '0;
                end else begin
                    scnt_nx  = scnt_q + 8'd1;
                end
            end
`endif
            PH3: begin
                eclk_nx  = 1'b0;
                stb_nx   = 1'b1;
                state_nx = PH0;
                if (!rstn_q && hold_q != HOLD_LAST) begin
                    hold_nx = hold_inc;
                    if (hold_inc == HOLD_LAST) rstn_nx = 1'b1;
                end
            end
            default: state_nx = PH0;
        endcase
        // Soft reset overrides a hold completing on the same edge
        if (bus.soft_rst) begin
            rstn_nx = 1'b0;
            hold_nx = '0;
        end
    end

    assign bus.qclk        = qclk_q;
    assign bus.eclk        = eclk_q;
    assign bus.cpu_reset_n = rstn_q;
    assign bus.ecycle_stb  = stb_q;
`ifdef CLKSEQ_STRETCH_EN
    assign bus.stretch_active = (state == STRETCH);
`else
    assign bus.stretch_active = 1'b0;
`endif

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Scoreboard bench: each driven E cycle pushes its expected shape; the monitor checks it on ecycle_stb.
module tb_clock_reset_sequencer;
    localparam int RESET_ECYCLES = 16;
    localparam int STRETCH_MAX   = 32;
`ifdef CLKSEQ_STRETCH_EN
    localparam bit STRETCH_EN = 1'b1;
`else
    localparam bit STRETCH_EN = 1'b0;
`endif

    typedef struct {
        int   period;
        int   ehigh;
        int   qhigh;
        int   qlead;
        int   st;
        logic rstn;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    clock_reset_sequencer_if bus();

    clock_reset_sequencer #(
        .RESET_ECYCLES (RESET_ECYCLES),
        .STRETCH_MAX   (STRETCH_MAX)
    ) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   fails  = 0;
    int   hold_m = 0;
    bit   rstn_m = 1'b0;
    int   ncyc   = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One E cycle: s = requested stretch clks, force_m = mrdy stuck low,
    // soft_k = edge (1-based) carrying a soft_rst pulse, soft_all = soft_rst on every edge.
    task automatic run_cycle(input int s, input bit force_m, input int soft_k, input bit soft_all);
        int   se;
        int   len;
        exp_t e;
        se  = !STRETCH_EN ? 0 : (force_m ? STRETCH_MAX : s);
        len = 4 + se;
        for (int k = 1; k <= len; k++) begin
            if (soft_all || k == soft_k) begin
                hold_m = 0;
                rstn_m = 1'b0;
            end else if (k == len && !rstn_m) begin
                hold_m++;
                if (hold_m == RESET_ECYCLES) rstn_m = 1'b1;
            end
        end
        e.period = len;
        e.ehigh  = 2 + se;
        e.qhigh  = 2;
        e.qlead  = 1;
        e.st     = se;
        e.rstn   = rstn_m;
        exp_q.push_back(e);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            bus.mrdy     = force_m ? 1'b0 : !(k >= 3 && k <= 2 + s);
            bus.soft_rst = soft_all || (k == soft_k);
        end
    endtask

    // Start a cycle, assert reset mid-E (mid-stretch when stretching exists), restart.
    task automatic abort_mid();
        int n;
        n = STRETCH_EN ? 5 : 3;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            bus.mrdy     = !(k >= 3);
            bus.soft_rst = 1'b0;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        bus.mrdy = 1'b1;
        rst_n    = 1'b1;
        hold_m   = 0;
        rstn_m   = 1'b0;
    endtask

    int per = 0, eh = 0, qh = 0, ql = 0, st = 0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            per = 0; eh = 0; qh = 0; ql = 0; st = 0;
        end else begin
            per++;
            if (bus.eclk) eh++;
            if (bus.qclk) qh++;
            if (bus.qclk && !bus.eclk) ql++;
            if (bus.stretch_active) st++;
            if (bus.ecycle_stb) begin
                ncyc++;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL c%0d_unexpected_stb: got strobe expected none", ncyc);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("c%0d_period", ncyc), per, e.period);
                    check($sformatf("c%0d_eclk_high", ncyc), eh, e.ehigh);
                    check($sformatf("c%0d_qclk_high", ncyc), qh, e.qhigh);
                    check($sformatf("c%0d_q_lead", ncyc), ql, e.qlead);
                    check($sformatf("c%0d_stretch", ncyc), st, e.st);
                    check($sformatf("c%0d_cpu_reset_n", ncyc), bus.cpu_reset_n, e.rstn);
                end
                per = 0; eh = 0; qh = 0; ql = 0; st = 0;
            end
        end
    end

    always @(negedge rst_n) begin
        #1;
        check("async_reset_outputs",
              {bus.qclk, bus.eclk, bus.cpu_reset_n, bus.ecycle_stb, bus.stretch_active}, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.mrdy     = 1'b1;
        bus.soft_rst = 1'b0;
        rst_n        = 1'b1;
        #3 rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n     = 1'b1;

        repeat (20) run_cycle(0, 1'b0, 0, 1'b0);
        run_cycle(5, 1'b0, 0, 1'b0);
        run_cycle(1, 1'b0, 0, 1'b0);
        run_cycle(0, 1'b0, 0, 1'b0);
        run_cycle(2, 1'b0, 0, 1'b0);
        repeat (2) run_cycle(0, 1'b1, 0, 1'b0);
        run_cycle(0, 1'b0, 0, 1'b0);

        repeat (12) run_cycle(0, 1'b0, 0, 1'b0);
        run_cycle(0, 1'b0, 1, 1'b0);
        repeat (17) run_cycle(0, 1'b0, 0, 1'b0);

        run_cycle(0, 1'b0, 4, 1'b0);
        repeat (15) run_cycle(0, 1'b0, 0, 1'b0);
        run_cycle(0, 1'b0, 4, 1'b0);
        repeat (16) run_cycle(0, 1'b0, 0, 1'b0);

        repeat (3) run_cycle(0, 1'b0, 0, 1'b1);
        repeat (17) run_cycle(0, 1'b0, 0, 1'b0);

        abort_mid();
        repeat (17) run_cycle(3, 1'b0, 0, 1'b0);

        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
